// File: rtl/flash_sample_reader.sv
`default_nettype none
// ============================================================================
// Module      : flash_sample_reader
// Description : Streams fixed-width audio samples out of a word-wide flash.
//               One word is fetched at a time, then its sample lanes are
//               handed out one per sample_req. Word addresses walk upward or
//               downward between start_addr and end_addr, and either wrap
//               (loop) or stop in DONE at the boundary. Requests that arrive
//               while a word is still being fetched are counted as underruns.
// Ports       : clk50M, rst_n            - clock, async active-low reset
//               play_en, restart         - run/pause level, abort pulse
//               dir_rev, loop_en         - walk direction, wrap enable
//               start_addr, end_addr     - word address window
//               sample_req               - audio-rate consume strobe
//               flash_*                  - single-outstanding read master
//               sample_out, sample_valid - current sample and update strobe
//               busy, done, underrun_cnt - status
// Revision    : 1.0 - initial release
// ============================================================================
module flash_sample_reader #(
  parameter int DATA_W   = 32,
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 23
) (
  input  logic                clk50M,
  input  logic                rst_n,
  input  logic                play_en,
  input  logic                restart,
  input  logic                dir_rev,
  input  logic                loop_en,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic                sample_req,
  output logic                flash_read,
  output logic [ADDR_W-1:0]   flash_address,
  input  logic                flash_waitrequest,
  input  logic                flash_readdatavalid,
  input  logic [DATA_W-1:0]   flash_readdata,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                done,
  output logic [7:0]          underrun_cnt
);

  localparam int c_lanes  = DATA_W / SAMPLE_W;
  localparam int c_lane_w = (c_lanes > 1) ? $clog2(c_lanes) : 1;
  localparam logic [c_lane_w-1:0] c_lane_last = c_lane_w'(c_lanes - 1);
  localparam logic [c_lane_w-1:0] c_lane_one  = c_lane_w'(1);
  localparam logic [ADDR_W-1:0]   c_addr_one  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                           r_state;
  logic [ADDR_W-1:0]                r_addr;
  logic [DATA_W-1:0]                r_buffer;
  logic [c_lane_w-1:0]              r_lane;
  logic                             r_restart_pend;

  logic [c_lanes-1:0][SAMPLE_W-1:0] w_lanes;
  logic                             w_req;
  logic [ADDR_W-1:0]                w_reload;
  logic [ADDR_W-1:0]                w_step;
  logic                             w_boundary;
  logic [c_lane_w-1:0]              w_first_lane;
  logic [c_lane_w-1:0]              w_last_lane;
  logic [7:0]                       w_underrun_inc;

  // Lane 0 occupies the least significant bits of the flash word.
  assign w_lanes        = r_buffer;
  assign w_req          = play_en & sample_req;
  assign w_reload       = dir_rev ? end_addr : start_addr;
  // Modulo arithmetic: a window with start > end wraps through address 0.
  assign w_step         = dir_rev ? (r_addr - c_addr_one) : (r_addr + c_addr_one);
  assign w_boundary     = (r_addr == (dir_rev ? start_addr : end_addr));
  assign w_first_lane   = dir_rev ? c_lane_last : '0;
  assign w_last_lane    = dir_rev ? '0 : c_lane_last;
  assign w_underrun_inc = (underrun_cnt == 8'hFF) ? 8'hFF : (underrun_cnt + 8'd1);

  assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_buffer       <= '0;
      r_lane         <= '0;
      r_restart_pend <= 1'b0;
      flash_read     <= 1'b0;
      flash_address  <= '0;
      sample_out     <= '0;
      sample_valid   <= 1'b0;
      underrun_cnt   <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (restart) begin
            underrun_cnt <= '0;
          end else if (play_en) begin
            r_addr        <= w_reload;
            flash_address <= w_reload;
            flash_read    <= 1'b1;
            r_state       <= S_FETCH;
          end
        end

        S_FETCH: begin
          // A restart cannot abandon an issued read; remember it until the
          // data returns so only one read is ever outstanding.
          if (restart) r_restart_pend <= 1'b1;
          if (w_req)   underrun_cnt   <= w_underrun_inc;
          if (!flash_waitrequest) begin
            flash_read <= 1'b0;
            r_state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (flash_readdatavalid) begin
            if (restart || r_restart_pend) begin
              // Returned word is dropped; abort lands in IDLE.
              r_restart_pend <= 1'b0;
              underrun_cnt   <= '0;
              r_state        <= S_IDLE;
            end else begin
              r_buffer <= flash_readdata;
              r_lane   <= w_first_lane;
              r_state  <= S_HOLD;
              if (w_req) underrun_cnt <= w_underrun_inc;
            end
          end else begin
            if (restart) r_restart_pend <= 1'b1;
            if (w_req)   underrun_cnt   <= w_underrun_inc;
          end
        end

        S_HOLD: begin
          if (restart) begin
            underrun_cnt <= '0;
            r_state      <= S_IDLE;
          end else if (w_req) begin
            sample_out   <= w_lanes[r_lane];
            sample_valid <= 1'b1;
            if (r_lane == w_last_lane) begin
              if (!w_boundary || loop_en) begin
                r_addr        <= w_boundary ? w_reload : w_step;
                flash_address <= w_boundary ? w_reload : w_step;
                flash_read    <= 1'b1;
                r_state       <= S_FETCH;
              end else begin
                r_state <= S_DONE;
              end
            end else begin
              r_lane <= dir_rev ? (r_lane - c_lane_one) : (r_lane + c_lane_one);
            end
          end
        end

        S_DONE: begin
          if (restart) begin
            underrun_cnt <= '0;
            r_state      <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/flash_sample_reader.md
FLASH_SAMPLE_READER -- requirements
Module: flash_sample_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, flash word width in bits.
REQ-002 SHALL have parameter SAMPLE_W, default 16, sample width; DATA_W SHALL be an integer multiple; N = DATA_W/SAMPLE_W lanes per word.
REQ-003 SHALL have parameter ADDR_W, default 23, flash word-address width.
REQ-004 Ports (name  direction  width  meaning):
 clk50M  in  1  single clock, all state on rising edge
 rst_n  in  1  reset, asynchronous, active-low
 play_en  in  1  level; 1 = run/consume, 0 = pause
 restart  in  1  one-cycle pulse; abort and return to IDLE
 dir_rev  in  1  0 = ascending addresses/lanes, 1 = descending
 loop_en  in  1  1 = wrap at boundary, 0 = stop at boundary
 start_addr  in  ADDR_W  first word address (forward)
 end_addr  in  ADDR_W  last word address (forward)
 sample_req  in  1  one-cycle pulse from audio-rate synchronizer
 flash_read  out  1  read request to flash controller
 flash_address  out  ADDR_W  word address of request
 flash_waitrequest  in  1  controller stall
 flash_readdatavalid  in  1  read data valid strobe
 flash_readdata  in  DATA_W  read data
 sample_out  out  SAMPLE_W  current sample, held between updates
 sample_valid  out  1  one-cycle pulse when sample_out updates
 busy  out  1  1 in any state except IDLE and DONE
 done  out  1  1 in DONE
 underrun_cnt  out  8  saturating count of unserviced sample_req

Function
REQ-005 SHALL implement states IDLE, FETCH, WAIT, HOLD, DONE.
REQ-006 IDLE: when play_en=1, load addr = start_addr (dir_rev=0) or end_addr (dir_rev=1), go FETCH next cycle.
REQ-007 FETCH: flash_read=1, flash_address=addr; held stable while flash_waitrequest=1; on cycle with flash_waitrequest=0 go WAIT, flash_read=0 from next cycle.
REQ-008 WAIT: on flash_readdatavalid=1 capture flash_readdata into word buffer, lane = 0 (forward) or N-1 (reverse), go HOLD.
REQ-009 HOLD with play_en=1 and sample_req=1: sample_out <= buffer bits [lane*SAMPLE_W +: SAMPLE_W], sample_valid=1 for exactly the following cycle; lane steps +1 (forward) or -1 (reverse).
REQ-010 On consumption of the last lane (N-1 forward, 0 reverse) SHALL compute next address and go FETCH, or DONE per REQ-011.
REQ-011 Boundary: forward at addr==end_addr, reverse at addr==start_addr; loop_en=1 reloads per REQ-006 and goes FETCH; loop_en=0 goes DONE. Non-boundary: addr +1 / -1 modulo 2^ADDR_W (equality compare only; start>end wraps through 0).
REQ-012 sample_req with play_en=1 in FETCH or WAIT (including the readdatavalid cycle) SHALL increment underrun_cnt, saturating at 255; no sample_valid.
REQ-013 play_en=0: sample_req ignored in all states (no output, no underrun); an outstanding FETCH/WAIT completes into HOLD.
REQ-014 restart in IDLE, HOLD or DONE: go IDLE next cycle, clear underrun_cnt; in FETCH/WAIT: deferred, taking effect the cycle after readdatavalid (data discarded, sample_valid not asserted).
REQ-015 restart has priority over sample_req in the same cycle.
REQ-016 DONE: done=1, flash_read=0, sample_req ignored; exits only by restart.
REQ-017 dir_rev, loop_en, start_addr, end_addr sampled when used; changes take effect at next address computation.
REQ-018 At most one flash read outstanding at any time.

Reset
REQ-019 rst_n=0 SHALL asynchronously force: state IDLE, flash_read 0, flash_address 0, sample_out 0, sample_valid 0, busy 0, done 0, underrun_cnt 0, word buffer 0, lane 0, addr 0.
REQ-020 Reset mid-read SHALL abandon the request; a flash_readdatavalid arriving after release in IDLE SHALL be ignored.

Verification
REQ-021 Forward: start=0x10, end=0x11, loop_en=0, words 0xAAAA5555, 0x22221111, 5 sample_req -> samples 0x5555, 0xAAAA, 0x1111, 0x2222; done=1; underrun_cnt=0.
REQ-022 Reverse: same setup, dir_rev=1 -> 0x2222, 0x1111, 0xAAAA, 0x5555; address order 0x11, 0x10.
REQ-023 Loop: start=end=0x7FFFFF, loop_en=1 -> repeated reads of 0x7FFFFF, done never set.
REQ-024 Stall: waitrequest high 5 cycles, sample_req every 2 cycles during FETCH/WAIT -> flash_address stable, underrun_cnt equals pulses counted, saturates at 255 after 300 pulses.
REQ-025 restart during WAIT -> IDLE the cycle after readdatavalid, no sample_valid, underrun_cnt=0.
REQ-026 rst_n low mid-HOLD -> all outputs at REQ-019 values immediately, without clock edge.
